// File: rtl/vote_pkg.sv
// Shared definitions for the vote logger and the display stage that reads its results.
package vote_pkg;

  typedef enum logic [1:0] {
    VOTE    = 2'd0,
    LOCKOUT = 2'd1,
    RESULT  = 2'd2
  } vote_state_t;

  localparam logic MODE_VOTE   = 1'b0;
  localparam logic MODE_RESULT = 1'b1;

endpackage

// File: rtl/vote_sat_counter.sv
// Saturating up-counter. sat is high when the count is all-ones or becomes all-ones on this edge.
module vote_sat_counter
  import vote_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

  // Look ahead one edge so the sticky flag rises together with the count.
  assign sat = (count == MAX) | (inc & (count == MAX - CNT_W'(1)));

endmodule

// File: rtl/vote_logger.sv
// Per-candidate vote tally with one-vote-at-a-time lockout and a result display mode.
module vote_logger
  import vote_pkg::*;
#(
  parameter  int NUM_CAND    = 4,
  parameter  int CNT_W       = 8,
  parameter  int LOCK_CYCLES = 16,
  localparam int SEL_W       = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic [NUM_CAND-1:0] vote_valid,
  input  logic [SEL_W-1:0]    result_sel,
  output logic                vote_ack,
  output logic                multi_err,
  output logic                busy,
  output logic                sat_flag,
  output logic [NUM_CAND-1:0] vote_leds,
  output logic [CNT_W-1:0]    result_count,
  output logic [CNT_W-1:0]    total_votes
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_CYCLES - 1);

  vote_state_t         state, state_n;
  logic [LOCK_W-1:0]   lock_cnt, lock_cnt_n;
  logic                accept, multi;
  logic [NUM_CAND-1:0] inc_vec;
  logic [NUM_CAND:0]   sat_vec;
  logic [CNT_W-1:0]    cnt     [NUM_CAND];
  logic [CNT_W-1:0]    cnt_pad [2**SEL_W];

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cand
    vote_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc_vec[i]),
      .count (cnt[i]),
      .sat   (sat_vec[i])
    );
  end

  vote_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clock (clock),
    .reset (reset),
    .inc   (accept),
    .count (total_votes),
    .sat   (sat_vec[NUM_CAND])
  );

  // Unused select codes read as zero when NUM_CAND is not a power of two.
  for (genvar j = 0; j < 2**SEL_W; j++) begin : g_pad
    if (j < NUM_CAND) begin : g_real
      assign cnt_pad[j] = cnt[j];
    end else begin : g_zero
      assign cnt_pad[j] = '0;
    end
  end

  assign inc_vec = accept ? vote_valid : '0;

  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    accept     = 1'b0;
    multi      = 1'b0;
    case (state)
      VOTE: begin
        if (mode == MODE_RESULT) begin
          state_n = RESULT;
        end else if ($onehot(vote_valid)) begin
          accept     = 1'b1;
          state_n    = LOCKOUT;
          lock_cnt_n = LOCK_INIT;
        end else if (|vote_valid) begin
          multi = 1'b1;
        end
      end
      LOCKOUT: begin
        if (mode == MODE_RESULT) begin
          state_n = RESULT;
        end else if (lock_cnt == '0) begin
          state_n = VOTE;
        end else begin
          lock_cnt_n = lock_cnt - LOCK_W'(1);
        end
      end
      RESULT: begin
        if (mode == MODE_VOTE) state_n = VOTE;
      end
      default: state_n = VOTE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= VOTE;
      lock_cnt     <= '0;
      vote_ack     <= 1'b0;
      multi_err    <= 1'b0;
      busy         <= 1'b0;
      sat_flag     <= 1'b0;
      vote_leds    <= '0;
      result_count <= '0;
    end else begin
      state     <= state_n;
      lock_cnt  <= lock_cnt_n;
      vote_ack  <= accept;
      multi_err <= multi;
      busy      <= (state_n == LOCKOUT);
      sat_flag  <= sat_flag | (|sat_vec);
      if (state_n == RESULT) begin
        vote_leds    <= '0;
        result_count <= cnt_pad[result_sel];
      end else begin
        result_count <= '0;
        if (accept) vote_leds <= vote_valid;
      end
    end
  end

endmodule

// File: tb/tb_vote_logger.sv
// Randomized and directed bench for vote_logger against a cycle-level behavioural model.
module tb_vote_logger;

  localparam int NUM_CAND    = 4;
  localparam int CNT_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int MAXV        = (1 << CNT_W) - 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                mode;
  logic [NUM_CAND-1:0] vote_valid;
  logic [1:0]          result_sel;
  logic                vote_ack, multi_err, busy, sat_flag;
  logic [NUM_CAND-1:0] vote_leds;
  logic [CNT_W-1:0]    result_count, total_votes;

  vote_logger #(.NUM_CAND(NUM_CAND), .CNT_W(CNT_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clock        (clock),
    .reset        (reset),
    .mode         (mode),
    .vote_valid   (vote_valid),
    .result_sel   (result_sel),
    .vote_ack     (vote_ack),
    .multi_err    (multi_err),
    .busy         (busy),
    .sat_flag     (sat_flag),
    .vote_leds    (vote_leds),
    .result_count (result_count),
    .total_votes  (total_votes)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: tallies, lockout remaining, display flag.
  int       m_cnt [NUM_CAND];
  int       m_total;
  bit       m_in_result;
  int       m_lock_left;
  bit       m_sat;
  bit [3:0] m_leds;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CAND; i++) m_cnt[i] = 0;
    m_total = 0; m_in_result = 0; m_lock_left = 0; m_sat = 0; m_leds = '0;
  endfunction

  task automatic step(input logic m, input logic [3:0] vv, input logic [1:0] sel);
    bit acc, mul;
    int idx, exp_rc;
    mode = m; vote_valid = vv; result_sel = sel;
    @(posedge clock);
    acc = 0; mul = 0; idx = 0;
    if (m) begin
      m_in_result = 1; m_lock_left = 0;
    end else if (m_in_result) begin
      m_in_result = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if ($countones(vv) == 1) begin
      acc = 1;
    end else if ($countones(vv) > 1) begin
      mul = 1;
    end
    if (acc) begin
      for (int i = 0; i < NUM_CAND; i++) if (vv[i]) idx = i;
      if (m_cnt[idx] < MAXV) m_cnt[idx]++;
      if (m_total < MAXV) m_total++;
      m_lock_left = LOCK_CYCLES;
      m_leds = vv;
    end
    if (m_in_result) m_leds = '0;
    exp_rc = m_in_result ? m_cnt[sel] : 0;
    for (int i = 0; i < NUM_CAND; i++) if (m_cnt[i] == MAXV) m_sat = 1;
    if (m_total == MAXV) m_sat = 1;
    #1;
    chk("vote_ack", vote_ack, acc);
    chk("multi_err", multi_err, mul);
    chk("busy", busy, (m_lock_left > 0));
    chk("vote_leds", vote_leds, m_leds);
    chk("result_count", result_count, exp_rc);
    chk("total_votes", total_votes, m_total);
    chk("sat_flag", sat_flag, m_sat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 4'b0000, 2'd0);
  endtask

  // Called 1 time unit after an edge: asserts reset between edges and checks the immediate clear.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_total", total_votes, 0);
    chk("arst_leds", vote_leds, 0);
    chk("arst_ack", vote_ack, 0);
    chk("arst_sat", sat_flag, 0);
    chk("arst_rc", result_count, 0);
    #2 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int busy_len;
    logic m_rand;
    reset = 1'b1; mode = 1'b0; vote_valid = '0; result_sel = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", vote_ack, 0);
    chk("rst_multi", multi_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_leds", vote_leds, 0);
    chk("rst_rc", result_count, 0);
    chk("rst_total", total_votes, 0);
    #3 reset = 1'b0;

    // First vote on candidate 2, then measure the lockout length.
    step(0, 4'b0100, 2'd0);
    chk("first_leds", vote_leds, 4'b0100);
    chk("first_ack", vote_ack, 1);
    busy_len = 0;
    if (busy) busy_len++;
    for (int i = 0; i < 20; i++) begin
      step(0, (i == 4) ? 4'b0010 : 4'b0000, 2'd0);
      if (busy) busy_len++;
    end
    chk("busy_len", busy_len, LOCK_CYCLES);
    step(0, 4'b0010, 2'd0);
    chk("late_ack", vote_ack, 1);
    idle(17);

    // Multiple bits set in VOTE.
    step(0, 4'b0011, 2'd0);
    chk("multi_pulse", multi_err, 1);
    step(0, 4'b0000, 2'd0);
    chk("multi_one_cycle", multi_err, 0);
    step(1, 4'b0000, 2'd1);
    chk("cnt1_after", result_count, 1);
    step(1, 4'b0000, 2'd2);
    chk("cnt2_after", result_count, 1);
    step(0, 4'b0000, 2'd0);

    // Saturate candidate 0: holding the pulse is accepted once per lockout.
    for (int v = 0; v < 256; v++) begin
      step(0, 4'b0001, 2'd0);
      idle(16);
    end
    step(0, 4'b0001, 2'd0);
    chk("sat_ack", vote_ack, 1);
    chk("sat_flag_set", sat_flag, 1);
    idle(20);
    chk("sat_sticky", sat_flag, 1);
    step(1, 4'b0000, 2'd0);
    chk("sat_cnt0", result_count, MAXV);

    // Fresh tallies 3/1/0/2 and result readout.
    step(0, 4'b0000, 2'd0);
    async_reset();
    for (int c = 0; c < NUM_CAND; c++) begin
      for (int k = 0; k < ((c == 0) ? 3 : (c == 1) ? 1 : (c == 2) ? 0 : 2); k++) begin
        step(0, 4'(1 << c), 2'd0);
        idle(16);
      end
    end
    for (int s = 0; s < NUM_CAND; s++) step(1, 4'b0000, 2'(s));
    chk("rc_sel3", result_count, 2);
    step(1, 4'b0100, 2'd0);
    step(1, 4'b1000, 2'd0);
    chk("rc_sel0", result_count, 3);
    step(1, 4'b0100, 2'd2);
    chk("rc_sel2_ignored", result_count, 0);
    step(0, 4'b0000, 2'd0);

    // Reset in the middle of a lockout, then the first pulse must be accepted.
    step(0, 4'b1000, 2'd0);
    idle(5);
    chk("mid_lock_busy", busy, 1);
    async_reset();
    step(0, 4'b0010, 2'd0);
    chk("post_rst_ack", vote_ack, 1);
    chk("post_rst_total", total_votes, 1);

    // Randomized traffic.
    m_rand = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] vv;
      int r;
      if ($urandom_range(0, 19) == 0) m_rand = ~m_rand;
      r = $urandom_range(0, 9);
      if (r < 5)      vv = 4'b0000;
      else if (r < 8) vv = 4'(1 << $urandom_range(0, 3));
      else            vv = 4'($urandom_range(0, 15));
      step(m_rand, vv, 2'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
